// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding, width defaults and timer sizing for the memory access controller
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 16;
  localparam int MEM_DEPTH_DEF   = 256;
  localparam int WAIT_CYCLES_DEF = 1;

  // A zero-wait build still needs a one-bit counter.
  function automatic int timer_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - loadable down-counter that times the strobe window, with zero flag
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int              CW   = timer_width(WAIT_CYCLES);
  localparam logic [CW-1:0]   INIT = CW'(WAIT_CYCLES);

  logic [CW-1:0] count;

  // Saturates at zero; only a load from IDLE restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= INIT;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request load/store sequencer driving the 16-bit data Memory
// Optional out-of-range address rejection: MEM_ACCESS_ADDR_CHECK_EN
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(MEM_DEPTH);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic              accept;
  logic              addr_bad;
  logic              timer_zero;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;

`ifdef MEM_ACCESS_ADDR_CHECK_EN
  assign addr_bad = ({1'b0, req_addr} >= DEPTH_CMP);
`else
  logic unused_depth;
  assign addr_bad     = 1'b0;
  assign unused_depth = ^DEPTH_CMP;
`endif

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (accept && !addr_bad),
    .dec   (state == ST_ACCESS),
    .zero  (timer_zero)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          next_state = addr_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (timer_zero) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // req_ready is registered so it stays low through reset and rises one edge after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == ST_IDLE);
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (addr_bad) begin
              rsp_valid <= 1'b1;
            end else begin
              write_q   <= req_write;
              addr_q    <= req_addr;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              mem_read  <= !req_write;
              mem_write <= req_write;
            end
          end
        end
        ST_ACCESS: begin
          if (timer_zero) begin
            // Parking on the inverse forces an address change before a repeat access.
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= ~addr_q;
            rsp_valid <= 1'b1;
            if (!write_q) begin
              rsp_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_ADDR_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= accept && addr_bad;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl with a behavioural Memory
module tb_mem_access_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem_arr [256];

  int n_pass  = 0;
  int n_total = 0;

  int          obs_wait;
  int          obs_strobes;
  int          obs_rsp_cnt;
  int          obs_rsp_off;
  int          obs_ready_low;
  logic        obs_is_write;
  logic [15:0] obs_addr;
  logic [15:0] obs_wdata;
  logic [15:0] obs_park;
  logic [15:0] obs_rdata;
  logic        obs_err;

  mem_access_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = mem_read ? mem_arr[mem_addr[7:0]] : 16'h0000;

  always @(posedge clock) begin
    if (mem_write) mem_arr[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and records what the Memory side and response side showed, offset 1 = cycle after accept.
  task automatic run_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    obs_wait = 0; obs_strobes = 0; obs_rsp_cnt = 0; obs_rsp_off = -1; obs_ready_low = 0;
    obs_is_write = 1'bx; obs_addr = 16'hxxxx; obs_wdata = 16'hxxxx;
    obs_park = 16'hxxxx; obs_rdata = 16'hxxxx; obs_err = 1'bx;
    while (req_ready !== 1'b1 && obs_wait < 20) begin
      step();
      obs_wait++;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    for (int k = 1; k <= 20; k++) begin
      if (mem_read || mem_write) begin
        if (obs_strobes == 0) begin
          obs_addr = mem_addr; obs_wdata = mem_wdata; obs_is_write = mem_write;
        end
        obs_strobes++;
      end
      if (rsp_valid) begin
        obs_rsp_cnt++; obs_rsp_off = k; obs_park = mem_addr; obs_rdata = rsp_rdata; obs_err = rsp_err;
      end
      if (req_ready) break;
      obs_ready_low++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0055; req_wdata = 16'h7777;
    step(); step(); step();
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_total++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); else n_pass++;
    n_total++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 16'h0000) $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); else n_pass++;
    n_total++; if (rsp_rdata !== 16'h0000) $display("FAIL reset_rsp_rdata got=%h exp=0000", rsp_rdata); else n_pass++;
    n_total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); else n_pass++;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    step();
    n_total++; if (req_ready !== 1'b1) $display("FAIL release_req_ready got=%b exp=1", req_ready); else n_pass++;
  endtask

  task automatic test_store();
    run_req(1'b1, 16'h0012, 16'hBEEF);
    n_total++; if (obs_strobes !== 2) $display("FAIL store_strobe_cycles got=%0d exp=2", obs_strobes); else n_pass++;
    n_total++; if (obs_is_write !== 1'b1) $display("FAIL store_is_write got=%b exp=1", obs_is_write); else n_pass++;
    n_total++; if (obs_addr !== 16'h0012) $display("FAIL store_mem_addr got=%h exp=0012", obs_addr); else n_pass++;
    n_total++; if (obs_wdata !== 16'hBEEF) $display("FAIL store_mem_wdata got=%h exp=BEEF", obs_wdata); else n_pass++;
    n_total++; if (obs_rsp_off !== 3) $display("FAIL store_rsp_latency got=%0d exp=3", obs_rsp_off); else n_pass++;
    n_total++; if (obs_rsp_cnt !== 1) $display("FAIL store_rsp_pulses got=%0d exp=1", obs_rsp_cnt); else n_pass++;
    n_total++; if (obs_park !== 16'hFFED) $display("FAIL store_park_addr got=%h exp=FFED", obs_park); else n_pass++;
    n_total++; if (obs_rdata !== 16'h0000) $display("FAIL store_rdata_kept got=%h exp=0000", obs_rdata); else n_pass++;
    n_total++; if (mem_arr[8'h12] !== 16'hBEEF) $display("FAIL store_mem_content got=%h exp=BEEF", mem_arr[8'h12]); else n_pass++;
  endtask

  task automatic test_load();
    run_req(1'b0, 16'h0012, 16'h0000);
    n_total++; if (obs_strobes !== 2) $display("FAIL load_strobe_cycles got=%0d exp=2", obs_strobes); else n_pass++;
    n_total++; if (obs_is_write !== 1'b0) $display("FAIL load_is_write got=%b exp=0", obs_is_write); else n_pass++;
    n_total++; if (obs_rsp_off !== 3) $display("FAIL load_rsp_latency got=%0d exp=3", obs_rsp_off); else n_pass++;
    n_total++; if (obs_rdata !== 16'hBEEF) $display("FAIL load_rdata got=%h exp=BEEF", obs_rdata); else n_pass++;
    n_total++; if (obs_err !== 1'b0) $display("FAIL load_rsp_err got=%b exp=0", obs_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 16'h0005, 16'h0000);
    n_total++; if (obs_addr !== 16'h0005) $display("FAIL b2b_first_addr got=%h exp=0005", obs_addr); else n_pass++;
    n_total++; if (obs_rdata !== 16'h1234) $display("FAIL b2b_first_rdata got=%h exp=1234", obs_rdata); else n_pass++;
    n_total++; if (obs_park !== 16'hFFFA) $display("FAIL b2b_park_addr got=%h exp=FFFA", obs_park); else n_pass++;
    n_total++; if (obs_ready_low !== 3) $display("FAIL b2b_first_ready_low got=%0d exp=3", obs_ready_low); else n_pass++;
    run_req(1'b0, 16'h0005, 16'h0000);
    n_total++; if (obs_wait !== 0) $display("FAIL b2b_accept_gap got=%0d exp=0", obs_wait); else n_pass++;
    n_total++; if (obs_addr !== 16'h0005) $display("FAIL b2b_second_addr got=%h exp=0005", obs_addr); else n_pass++;
    n_total++; if (obs_rdata !== 16'h1234) $display("FAIL b2b_second_rdata got=%h exp=1234", obs_rdata); else n_pass++;
    n_total++; if (obs_ready_low !== 3) $display("FAIL b2b_second_ready_low got=%0d exp=3", obs_ready_low); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int rsp_seen;
    int wait_n;
    rsp_seen = 0;
    wait_n = 0;
    while (req_ready !== 1'b1 && wait_n < 20) begin
      step();
      wait_n++;
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030; req_wdata = 16'hAAAA;
    step();
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    n_total++; if (mem_write !== 1'b1) $display("FAIL midrst_in_access got=%b exp=1", mem_write); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL midrst_strobes_drop got=%b exp=00", {mem_read, mem_write}); else n_pass++;
    n_total++; if (mem_addr !== 16'h0000) $display("FAIL midrst_mem_addr got=%h exp=0000", mem_addr); else n_pass++;
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) rsp_seen++;
      step();
    end
    n_total++; if (rsp_seen !== 0) $display("FAIL midrst_no_rsp got=%0d exp=0", rsp_seen); else n_pass++;
    n_total++; if (mem_arr[8'h30] !== 16'h0000) $display("FAIL midrst_no_write got=%h exp=0000", mem_arr[8'h30]); else n_pass++;
    run_req(1'b0, 16'h0012, 16'h0000);
    n_total++; if (obs_strobes !== 2) $display("FAIL midrst_next_strobes got=%0d exp=2", obs_strobes); else n_pass++;
    n_total++; if (obs_rsp_off !== 3) $display("FAIL midrst_next_latency got=%0d exp=3", obs_rsp_off); else n_pass++;
    n_total++; if (obs_rdata !== 16'hBEEF) $display("FAIL midrst_next_rdata got=%h exp=BEEF", obs_rdata); else n_pass++;
  endtask

  task automatic test_addr_check();
    run_req(1'b0, 16'h0100, 16'h0000);
`ifdef MEM_ACCESS_ADDR_CHECK_EN
    n_total++; if (obs_strobes !== 0) $display("FAIL chk_no_strobe got=%0d exp=0", obs_strobes); else n_pass++;
    n_total++; if (obs_rsp_off !== 1) $display("FAIL chk_rsp_latency got=%0d exp=1", obs_rsp_off); else n_pass++;
    n_total++; if (obs_err !== 1'b1) $display("FAIL chk_rsp_err got=%b exp=1", obs_err); else n_pass++;
    n_total++; if (obs_rdata !== 16'hBEEF) $display("FAIL chk_rdata_kept got=%h exp=BEEF", obs_rdata); else n_pass++;
    n_total++; if (obs_park !== 16'hFFED) $display("FAIL chk_mem_addr_kept got=%h exp=FFED", obs_park); else n_pass++;
`else
    n_total++; if (obs_strobes !== 2) $display("FAIL nochk_strobes got=%0d exp=2", obs_strobes); else n_pass++;
    n_total++; if (obs_addr !== 16'h0100) $display("FAIL nochk_mem_addr got=%h exp=0100", obs_addr); else n_pass++;
    n_total++; if (obs_rsp_off !== 3) $display("FAIL nochk_rsp_latency got=%0d exp=3", obs_rsp_off); else n_pass++;
    n_total++; if (obs_err !== 1'b0) $display("FAIL nochk_rsp_err got=%b exp=0", obs_err); else n_pass++;
    n_total++; if (obs_rdata !== 16'h0F0F) $display("FAIL nochk_rdata got=%h exp=0F0F", obs_rdata); else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
    mem_arr[8'h05] = 16'h1234;
    mem_arr[8'h00] = 16'h0F0F;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid_access();
    test_load();
    test_addr_check();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
